// File: rtl/arp_cam_victim_sel.sv
`default_nettype none
// ============================================================================
// arp_cam_victim_sel : victim-way selector for the ARP IPv4->MAC CAM
// (LFSR random, round-robin, free-slot override). Rev 1.0
// ============================================================================
module arp_cam_victim_sel #(
  parameter int           N    = 3,
  parameter int           R    = 2,
  parameter int           P    = 16,
  parameter logic [P-1:0] SEED = 16'hACE1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         seed_ld_i,
  input  logic [P-1:0] seed_i,
  input  logic         mode_i,
  input  logic [N-1:0] free_mask_i,
  input  logic         req_i,
  output logic         gnt_o,
  output logic [R-1:0] idx_o
);

  localparam logic [P-1:0] TAPS = P'(16'hB400);

  logic [P-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [R-1:0]   rr_q, rr_d;
  logic [R-1:0]   idx_q, idx_d;
  logic           gnt_q, gnt_d;
  logic [R-1:0]   free_idx;
  logic [R-1:0]   scaled;
  logic [P+R-1:0] prod;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

  // A zero seed would lock the LFSR, so it is replaced by the reset seed.
  always_comb begin
    lfsr_d = lfsr_step;
    if (seed_ld_i) begin
      lfsr_d = (seed_i == '0) ? SEED : seed_i;
    end
  end

  // Full-width product keeps the floor exact: Idx = (state*N) >> P.
  assign prod   = {{R{1'b0}}, lfsr_q} * (P+R)'(N);
  assign scaled = prod[P+R-1:P];

  always_comb begin
    free_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (free_mask_i[i]) begin
        free_idx = R'(i);
      end
    end
  end

  always_comb begin
    gnt_d = req_i;
    idx_d = idx_q;
    rr_d  = rr_q;
    if (req_i) begin
      if (free_mask_i != '0) begin
        idx_d = free_idx;
      end else if (!mode_i) begin
        idx_d = scaled;
      end else begin
        idx_d = rr_q;
        rr_d  = (rr_q == R'(N-1)) ? '0 : rr_q + R'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
      rr_q   <= '0;
      idx_q  <= '0;
      gnt_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      rr_q   <= rr_d;
      idx_q  <= idx_d;
      gnt_q  <= gnt_d;
    end
  end

  assign gnt_o = gnt_q;
  assign idx_o = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_cam_victim_sel.sv
`default_nettype none
// ============================================================================
// tb_arp_cam_victim_sel : directed vector table plus reset and full-period
// sequences for arp_cam_victim_sel (N=3, R=2, P=16). Rev 1.0
// ============================================================================
module tb_arp_cam_victim_sel;

  localparam int           N    = 3;
  localparam int           R    = 2;
  localparam int           P    = 16;
  localparam logic [P-1:0] SEED = 16'hACE1;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         seed_ld_i;
  logic [P-1:0] seed_i;
  logic         mode_i;
  logic [N-1:0] free_mask_i;
  logic         req_i;
  logic         gnt_o;
  logic [R-1:0] idx_o;

  int n_tests = 0;
  int n_fail  = 0;

  arp_cam_victim_sel #(.N(N), .R(R), .P(P), .SEED(SEED)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .seed_ld_i  (seed_ld_i),
    .seed_i     (seed_i),
    .mode_i     (mode_i),
    .free_mask_i(free_mask_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .idx_o      (idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         ld;
    logic [P-1:0] seed;
    logic         mode;
    logic [N-1:0] fm;
    logic         req;
    logic         gnt;
    logic [R-1:0] idx;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [P-1:0] sd, input logic md,
                       input logic [N-1:0] fm, input logic rq);
    seed_ld_i   = ld;
    seed_i      = sd;
    mode_i      = md;
    free_mask_i = fm;
    req_i       = rq;
  endtask

  function automatic logic [P-1:0] model_step(input logic [P-1:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int model_scale(input logic [P-1:0] s);
    return int'((32'(s) * 3) >> 16);
  endfunction

  initial begin
    logic [P-1:0] m;
    int cnt[3];
    int n_gnt;
    int n_mis;

    // Reset held with a request pending: outputs stay cleared.
    rst_ni = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (3) @(negedge clk_i);
    check("reset gnt", int'(gnt_o), 0);
    check("reset idx", int'(idx_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post-reset gnt", int'(gnt_o), 1);
    check("post-reset idx (0xACE1)", int'(idx_o), 2);

    //               ld    seed   mode  fm      req   gnt   idx
    vecs.push_back('{1'b1, 16'd21845, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 16'd21846, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 16'd43690, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 16'd43691, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b1, 16'd65535, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd2});
    // Zero seed -> 0xACE1, 0xE270, 0x7138 -> 2, 2, 1
    vecs.push_back('{1'b1, 16'd0,     1'b0, 3'b000, 1'b0, 1'b0, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd1});
    // Free-slot override
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b010, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b011, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b110, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b0, 1'b0, 2'd1});
    // Round-robin from RrCnt=0
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b100, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b1, 3'b000, 1'b1, 1'b1, 2'd0});
    // Same-cycle load and request uses the pre-load state (1 -> Idx 0)
    vecs.push_back('{1'b1, 16'd1,     1'b0, 3'b000, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 16'd43691, 1'b0, 3'b000, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 16'd0,     1'b0, 3'b000, 1'b0, 1'b0, 2'd2});

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].seed, vecs[i].mode, vecs[i].fm, vecs[i].req);
      @(negedge clk_i);
      check($sformatf("vec%0d gnt", i), int'(gnt_o), int'(vecs[i].gnt));
      check($sformatf("vec%0d idx", i), int'(idx_o), int'(vecs[i].idx));
    end

    // Asynchronous reset in the middle of a request drops the grant.
    drive(1'b0, '0, 1'b1, '0, 1'b1);
    @(negedge clk_i);
    check("pre-reset gnt", int'(gnt_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async reset gnt", int'(gnt_o), 0);
    check("async reset idx", int'(idx_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i  = 1'b0;
    @(negedge clk_i);
    check("gnt after release", int'(gnt_o), 0);
    req_i  = 1'b1;
    @(negedge clk_i);
    check("rr restarts at 0", int'(idx_o), 0);

    // Full period from reset: every state visited once, equal thirds.
    rst_ni = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    m     = SEED;
    cnt   = '{0, 0, 0};
    n_gnt = 0;
    n_mis = 0;
    for (int k = 0; k < 65535; k++) begin
      @(negedge clk_i);
      if (gnt_o) n_gnt++;
      if (int'(idx_o) != model_scale(m)) begin
        if (n_mis < 4)
          $display("FAIL period idx at step %0d: got %0d, expected %0d", k, idx_o, model_scale(m));
        n_mis++;
      end
      cnt[idx_o]++;
      m = model_step(m);
    end
    check("period idx mismatches", n_mis, 0);
    check("period grants", n_gnt, 65535);
    check("period count idx0", cnt[0], 21845);
    check("period count idx1", cnt[1], 21845);
    check("period count idx2", cnt[2], 21845);
    check("model returns to seed", int'(m), int'(SEED));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
